// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bundle: branch/stall control, instruction memory port, IF/ID outputs
interface fetch_unit_if;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] ins_in;
    logic [15:0] pc_out;
    logic [15:0] id_ins;
    logic [15:0] id_pc;
    logic        id_valid;
    logic [1:0]  id_opcode;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic [2:0]  id_rd;
    logic [7:0]  id_imm;
    logic [15:0] fetch_count;

    modport master (
        output stall, br_taken, br_target, ins_in,
        input  pc_out, id_ins, id_pc, id_valid,
        input  id_opcode, id_rs, id_rt, id_rd, id_imm, fetch_count
    );

    modport slave (
        input  stall, br_taken, br_target, ins_in,
        output pc_out, id_ins, id_pc, id_valid,
        output id_opcode, id_rs, id_rt, id_rd, id_imm, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, IF/ID register and predecode
module fetch_unit #(
    parameter int          MEM_BYTES = 100,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.slave bus
);
    logic [15:0] pc_q, pc_d;
    logic [15:0] ins_q, ins_d;
    logic [15:0] idpc_q, idpc_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  opcode_q;
    logic [2:0]  rs_q, rt_q, rd_q;
    logic [7:0]  imm_q;

    logic [16:0] pc_plus2;
    logic [15:0] seq_pc;
    logic [15:0] tgt_al;
    logic [15:0] br_pc;

    // Widened by one bit so PC+2 near 0xFFFF still compares correctly against MEM_BYTES
    assign pc_plus2 = {1'b0, pc_q} + 17'd2;
    assign seq_pc   = (pc_plus2 >= 17'(MEM_BYTES)) ? 16'h0000 : pc_plus2[15:0];
    assign tgt_al   = {bus.br_target[15:1], 1'b0};
    assign br_pc    = ({1'b0, tgt_al} >= 17'(MEM_BYTES)) ? RESET_PC : tgt_al;

    always_comb begin
        pc_d    = pc_q;
        ins_d   = ins_q;
        idpc_d  = idpc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (bus.br_taken) begin
            // Redirect wins over a decode stall; the wrong-path word becomes a bubble
            pc_d    = br_pc;
            ins_d   = 16'h0000;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d    = seq_pc;
            ins_d   = bus.ins_in;
            idpc_d  = pc_q;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ins_q    <= 16'h0000;
            idpc_q   <= 16'h0000;
            valid_q  <= 1'b0;
            cnt_q    <= 16'h0000;
            opcode_q <= 2'b00;
            rs_q     <= 3'b000;
            rt_q     <= 3'b000;
            rd_q     <= 3'b000;
            imm_q    <= 8'h00;
        end else begin
            pc_q     <= pc_d;
            ins_q    <= ins_d;
            idpc_q   <= idpc_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            opcode_q <= ins_d[15:14];
            rs_q     <= ins_d[13:11];
            rt_q     <= ins_d[10:8];
            rd_q     <= ins_d[7:5];
            imm_q    <= ins_d[7:0];
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.id_ins      = ins_q;
    assign bus.id_pc       = idpc_q;
    assign bus.id_valid    = valid_q;
    assign bus.fetch_count = cnt_q;
    assign bus.id_opcode   = opcode_q;
    assign bus.id_rs       = rs_q;
    assign bus.id_rt       = rt_q;
    assign bus.id_rd       = rd_q;
    assign bus.id_imm      = imm_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.MEM_BYTES(100), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:99];

    function automatic logic [7:0] rd_byte(input logic [15:0] a);
        return (a < 16'd100) ? mem[a] : 8'h00;
    endfunction

    assign bus.ins_in = {rd_byte(bus.pc_out), rd_byte(bus.pc_out + 16'd1)};

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] pc;
        logic [15:0] ins;
        logic [15:0] ipc;
        logic        vld;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic s, input logic b, input logic [15:0] t,
                       input logic [15:0] pc, input logic [15:0] ins, input logic [15:0] ipc,
                       input logic v, input logic [15:0] c);
        vec_t e;
        e.rst = r; e.stl = s; e.br = b; e.tgt = t;
        e.pc = pc; e.ins = ins; e.ipc = ipc; e.vld = v; e.cnt = c;
        vecs.push_back(e);
    endtask

    task automatic chk_state(input string tag, input vec_t e);
        chk({tag, " pc_out"},      {16'h0, bus.pc_out},      {16'h0, e.pc});
        chk({tag, " id_ins"},      {16'h0, bus.id_ins},      {16'h0, e.ins});
        chk({tag, " id_pc"},       {16'h0, bus.id_pc},       {16'h0, e.ipc});
        chk({tag, " id_valid"},    {31'h0, bus.id_valid},    {31'h0, e.vld});
        chk({tag, " fetch_count"}, {16'h0, bus.fetch_count}, {16'h0, e.cnt});
        chk({tag, " fields"},
            {6'h0, bus.id_opcode, bus.id_rs, bus.id_rt, bus.id_rd, bus.id_imm},
            {6'h0, e.ins[15:14], e.ins[13:11], e.ins[10:8], e.ins[7:5], e.ins[7:0]});
    endtask

    initial begin
        vec_t e;
        for (int i = 0; i < 100; i++) mem[i] = 8'h00;
        {mem[0],  mem[1]}  = 16'h5320;
        {mem[2],  mem[3]}  = 16'h4101;
        {mem[4],  mem[5]}  = 16'h8A40;
        {mem[6],  mem[7]}  = 16'hCC04;
        {mem[12], mem[13]} = 16'h6D63;
        {mem[96], mem[97]} = 16'h7777;
        {mem[98], mem[99]} = 16'h9999;

        //   rst stl br  tgt       pc        id_ins    id_pc     vld cnt
        add(1, 0, 0, 16'h0000, 16'd0,  16'h0000, 16'd0,  0, 16'd0);
        add(1, 0, 1, 16'h000C, 16'd0,  16'h0000, 16'd0,  0, 16'd0);
        add(0, 0, 0, 16'h0000, 16'd2,  16'h5320, 16'd0,  1, 16'd1);
        add(0, 0, 0, 16'h0000, 16'd4,  16'h4101, 16'd2,  1, 16'd2);
        add(0, 1, 0, 16'h0000, 16'd4,  16'h4101, 16'd2,  1, 16'd2);
        add(0, 1, 0, 16'h0000, 16'd4,  16'h4101, 16'd2,  1, 16'd2);
        add(0, 1, 0, 16'h0000, 16'd4,  16'h4101, 16'd2,  1, 16'd2);
        add(0, 0, 0, 16'h0000, 16'd6,  16'h8A40, 16'd4,  1, 16'd3);
        add(0, 0, 0, 16'h0000, 16'd8,  16'hCC04, 16'd6,  1, 16'd4);
        add(0, 0, 1, 16'h000C, 16'd12, 16'h0000, 16'd6,  0, 16'd4);
        add(0, 0, 0, 16'h0000, 16'd14, 16'h6D63, 16'd12, 1, 16'd5);
        add(0, 1, 1, 16'h0007, 16'd6,  16'h0000, 16'd12, 0, 16'd5);
        add(0, 0, 0, 16'h0000, 16'd8,  16'hCC04, 16'd6,  1, 16'd6);
        add(0, 0, 1, 16'h0080, 16'd0,  16'h0000, 16'd6,  0, 16'd6);
        add(0, 0, 1, 16'h0060, 16'd96, 16'h0000, 16'd6,  0, 16'd6);
        add(0, 0, 0, 16'h0000, 16'd98, 16'h7777, 16'd96, 1, 16'd7);
        add(0, 0, 0, 16'h0000, 16'd0,  16'h9999, 16'd98, 1, 16'd8);
        add(0, 0, 0, 16'h0000, 16'd2,  16'h5320, 16'd0,  1, 16'd9);
        add(0, 1, 0, 16'h0000, 16'd2,  16'h5320, 16'd0,  1, 16'd9);
        add(1, 1, 1, 16'h000C, 16'd0,  16'h0000, 16'd0,  0, 16'd0);
        add(0, 0, 0, 16'h0000, 16'd2,  16'h5320, 16'd0,  1, 16'd1);
        add(0, 0, 1, 16'h0062, 16'd98, 16'h0000, 16'd0,  0, 16'd1);
        add(0, 0, 0, 16'h0000, 16'd0,  16'h9999, 16'd98, 1, 16'd2);
        add(0, 0, 1, 16'h0065, 16'd0,  16'h0000, 16'd98, 0, 16'd2);
        add(0, 0, 0, 16'h0000, 16'd2,  16'h5320, 16'd0,  1, 16'd3);

        reset = 1'b1;
        bus.stall = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_target = 16'h0000;

        foreach (vecs[i]) begin
            @(negedge clk);
            reset         = vecs[i].rst;
            bus.stall     = vecs[i].stl;
            bus.br_taken  = vecs[i].br;
            bus.br_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            chk_state($sformatf("v%0d", i), vecs[i]);
        end

        // Branch inputs toggled mid-cycle must not reach pc_out before the edge
        @(negedge clk);
        bus.br_taken  = 1'b1;
        bus.br_target = 16'h0020;
        bus.stall     = 1'b0;
        #1;
        chk("comb_isolation pc_out", {16'h0, bus.pc_out}, 32'd2);
        bus.br_taken = 1'b0;
        @(posedge clk);
        #1;
        e.rst = 0; e.stl = 0; e.br = 0; e.tgt = 0;
        e.pc = 16'd4; e.ins = 16'h4101; e.ipc = 16'd2; e.vld = 1; e.cnt = 16'd4;
        chk_state("after_glitch", e);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
